// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one apb_master command port among NREQ requesters.
// Runs one APB transfer at a time and returns read data or a timeout error to the winner.
module apb_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 32,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               pclk,
  input  logic               preset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_wr,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               rsp_err,
  output logic [AW-1:0]      m_addr,
  output logic [DW-1:0]      m_wdata,
  output logic               m_wr,
  output logic               m_newd,
  input  logic               m_penable,
  input  logic               m_pready,
  input  logic [DW-1:0]      m_dataout
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [GW-1:0]   last_gnt;
  logic [GW-1:0]   gnt_p1;
  logic [CW-1:0]   cnt_q;
  logic [DW-1:0]   rdata_p2;
  logic            err_p2;
  logic            win_found;
  logic [GW-1:0]   win_idx;
  logic            done;
  logic            expired;

  assign done    = m_penable && m_pready;
  assign expired = (cnt_q == CW'(TIMEOUT - 1));

  // Round-robin search: first valid requester after the last one served.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!win_found && req_valid[(int'(last_gnt) + k) % NREQ]) begin
        win_found = 1'b1;
        win_idx   = GW'((int'(last_gnt) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_found) state_d = ACCESS;
      ACCESS:  if (done || expired) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Outputs with combinational timing; reset also masks the accept pulse.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state_q == IDLE && win_found && !preset)
      req_ready = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
    if (state_q == RESP)
      rsp_valid = {{(NREQ-1){1'b0}}, 1'b1} << gnt_p1;
  end

  // newd drops in the completion cycle so the master never chains a second transfer.
  assign m_newd    = (state_q == ACCESS) && !done;
  assign rsp_rdata = rdata_p2;
  assign rsp_err   = err_p2;

  // Stage p1: command capture at accept; stage p2: response capture at end of access.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      last_gnt <= GW'(NREQ - 1);
      gnt_p1   <= '0;
      cnt_q    <= '0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_wr     <= 1'b0;
      rdata_p2 <= '0;
      err_p2   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            gnt_p1  <= win_idx;
            m_addr  <= req_addr[int'(win_idx)*AW +: AW];
            m_wdata <= req_wdata[int'(win_idx)*DW +: DW];
            m_wr    <= req_wr[win_idx];
            cnt_q   <= '0;
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q + CW'(1);
          if (done) begin
            rdata_p2 <= m_wr ? '0 : m_dataout;
            err_p2   <= 1'b0;
          end else if (expired) begin
            rdata_p2 <= '0;
            err_p2   <= 1'b1;
          end
        end
        RESP: begin
          last_gnt <= gnt_p1;
          rdata_p2 <= '0;
          err_p2   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: behavioural APB master/slave, requester clients and a
// transaction-level reference model checked every cycle, plus directed scenarios.
module tb_apb_req_arbiter;
  localparam int NREQ = 4, AW = 32, DW = 8, TIMEOUT = 16;

  logic pclk = 1'b0;
  logic preset = 1'b1;
  logic [NREQ-1:0] req_valid, req_wr, req_ready, rsp_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [DW-1:0] rsp_rdata, m_wdata, m_dataout;
  logic rsp_err, m_wr, m_newd, m_penable, m_pready;
  logic [AW-1:0] m_addr;

  apb_req_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .preset(preset), .req_valid(req_valid), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wr(m_wr), .m_newd(m_newd),
    .m_penable(m_penable), .m_pready(m_pready), .m_dataout(m_dataout));

  always #5 pclk = ~pclk;

  // Behavioural APB master + slave: idle -> setup -> enable, slave inserts cur_w waits.
  int ms = 0, en_cnt = 0, cur_w = 0, setup_cnt = 0;
  logic [DW-1:0] cur_d = '0;
  int slv_w = 0;
  logic [DW-1:0] slv_data = '0;
  always @(posedge pclk or posedge preset) begin
    if (preset) begin
      ms <= 0;
      en_cnt <= 0;
    end else begin
      case (ms)
        0: if (m_newd) begin
          ms <= 1; setup_cnt <= setup_cnt + 1; cur_w <= slv_w; cur_d <= slv_data;
        end
        1: begin ms <= 2; en_cnt <= 0; end
        default: if (m_pready || !m_newd) ms <= 0; else en_cnt <= en_cnt + 1;
      endcase
    end
  end
  assign m_penable = (ms == 2);
  assign m_pready  = (ms == 2) && (en_cnt == cur_w);
  assign m_dataout = (ms == 2) ? cur_d : '0;

  // Requester clients
  logic [NREQ-1:0] pend = '0;
  logic [AW-1:0] c_addr [NREQ];
  logic [DW-1:0] c_wdata [NREQ];
  logic [NREQ-1:0] c_wr = '0;
  bit hold = 0, rmode = 0;

  // Reference model state and logs
  int cyc = 0, n_cmp = 0, n_err = 0;
  bit in_xfer = 0;
  int rsp_cyc = 0, gnt_cyc = 0, m_last = NREQ - 1, m_gnt = 0, late_seen = 0;
  logic exp_err;
  logic [DW-1:0] exp_rd;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;
  logic g_wr;
  logic [NREQ-1:0] obs_rdy;
  int gq_idx[$], gq_cyc[$], rq_idx[$], rq_cyc[$];
  logic [DW-1:0] rq_rd[$];
  logic rq_err[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
    pend[i] = 1'b1; c_addr[i] = a; c_wdata[i] = d; c_wr[i] = w;
  endtask

  task automatic drive();
    req_valid = pend;
    req_wr = c_wr;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = c_addr[i];
      req_wdata[i*DW +: DW] = c_wdata[i];
    end
  endtask

  task automatic observe();
    logic [NREQ-1:0] exp_rdy, exp_rv;
    logic exp_newd;
    bit found;
    int win, acc, r;
    obs_rdy = req_ready;
    if (preset) begin
      chk("rst_outs", {req_ready, rsp_valid, rsp_rdata, rsp_err, m_addr, m_wdata, m_wr, m_newd}, 64'd0);
      in_xfer = 0;
      m_last = NREQ - 1;
      return;
    end
    exp_rdy = '0;
    if (!in_xfer) begin
      found = 0; win = 0;
      for (int k = 1; k <= NREQ; k++)
        if (!found && req_valid[(m_last + k) % NREQ]) begin found = 1; win = (m_last + k) % NREQ; end
      if (found) begin
        if (rmode) begin
          r = $urandom_range(0, 9);
          slv_w = (r < 7) ? r % 4 : (r == 7) ? TIMEOUT - 3 : (r == 8) ? TIMEOUT - 2 : 40;
          slv_data = DW'($urandom);
        end
        exp_rdy[win] = 1'b1;
        in_xfer = 1; m_gnt = win; gnt_cyc = cyc;
        g_addr = c_addr[win]; g_wdata = c_wdata[win]; g_wr = c_wr[win];
        acc = 3 + slv_w;
        exp_err = (acc > TIMEOUT);
        rsp_cyc = cyc + (exp_err ? TIMEOUT : acc) + 1;
        exp_rd = (exp_err || g_wr) ? '0 : slv_data;
        gq_idx.push_back(win); gq_cyc.push_back(cyc);
      end
    end
    chk("req_ready", req_ready, exp_rdy);
    exp_newd = in_xfer && (cyc > gnt_cyc) && ((cyc <= rsp_cyc - 2) || (cyc == rsp_cyc - 1 && exp_err));
    chk("m_newd", m_newd, exp_newd);
    if (in_xfer && cyc > gnt_cyc && cyc < rsp_cyc)
      chk("m_cmd", {m_addr, m_wdata, m_wr}, {g_addr, g_wdata, g_wr});
    exp_rv = '0;
    if (in_xfer && cyc == rsp_cyc) exp_rv[m_gnt] = 1'b1;
    chk("rsp_valid", rsp_valid, exp_rv);
    chk("rsp_data", {rsp_rdata, rsp_err}, (exp_rv != 0) ? {exp_rd, exp_err} : 9'd0);
    if (rsp_valid != 0) begin
      win = 0;
      for (int i = NREQ - 1; i >= 0; i--) if (rsp_valid[i]) win = i;
      rq_idx.push_back(win); rq_cyc.push_back(cyc); rq_rd.push_back(rsp_rdata); rq_err.push_back(rsp_err);
    end
    if (m_penable && m_pready && in_xfer && cyc == rsp_cyc && exp_err) late_seen++;
    if (in_xfer && cyc == rsp_cyc) begin in_xfer = 0; m_last = m_gnt; end
  endtask

  task automatic post();
    for (int i = 0; i < NREQ; i++) begin
      if (obs_rdy[i] && !hold) pend[i] = 1'b0;
      if (rmode) begin
        if (!pend[i] && $urandom_range(0, 3) == 0)
          set_req(i, $urandom, DW'($urandom), 1'($urandom_range(0, 1)));
        else if (pend[i] && !obs_rdy[i] && $urandom_range(0, 31) == 0)
          pend[i] = 1'b0;
      end
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      drive();
      @(negedge pclk);
      observe();
      @(posedge pclk);
      #1;
      post();
      cyc++;
    end
  endtask

  task automatic expect_xfer(input string tag, input int g0, input int r0, input int idx,
                             input int lat, input logic [DW-1:0] rd, input logic err);
    chk({tag, "_seen"}, (gq_idx.size() > g0) && (rq_idx.size() > r0), 1);
    if (gq_idx.size() > g0 && rq_idx.size() > r0) begin
      chk({tag, "_gnt"}, gq_idx[g0], idx);
      chk({tag, "_rsp_idx"}, rq_idx[r0], idx);
      chk({tag, "_lat"}, rq_cyc[r0] - gq_cyc[g0], lat);
      chk({tag, "_rdata"}, rq_rd[r0], rd);
      chk({tag, "_err"}, rq_err[r0], err);
    end
  endtask

  initial begin
    int g0, r0, s0, l0;
    for (int i = 0; i < NREQ; i++) begin c_addr[i] = '0; c_wdata[i] = '0; end
    // Reset
    run(3);
    preset = 1'b0;
    run(2);
    // Single read, zero wait states
    set_req(2, 32'h0000_0010, 8'h00, 1'b0);
    slv_w = 0; slv_data = 8'hA5;
    g0 = gq_idx.size(); r0 = rq_idx.size();
    run(8);
    expect_xfer("rd", g0, r0, 2, 4, 8'hA5, 1'b0);
    // Single write, two wait states
    set_req(1, 32'h0000_0020, 8'h3C, 1'b1);
    slv_w = 2; slv_data = 8'h77;
    g0 = gq_idx.size(); r0 = rq_idx.size(); s0 = setup_cnt;
    run(10);
    expect_xfer("wr", g0, r0, 1, 6, 8'h00, 1'b0);
    chk("wr_setups", setup_cnt - s0, 1);
    // Round-robin fairness from reset
    preset = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h100 + i, 8'(i), 1'b0);
    hold = 1;
    run(2);
    preset = 1'b0;
    slv_w = 0; slv_data = 8'h11;
    g0 = gq_idx.size();
    run(31);
    for (int j = 0; j < 6; j++) begin
      chk("rr_have", gq_idx.size() > g0 + j + 1, 1);
      if (gq_idx.size() > g0 + j + 1) begin
        chk("rr_order", gq_idx[g0 + j], j % 4);
        chk("rr_spacing", gq_cyc[g0 + j + 1] - gq_cyc[g0 + j], 5);
      end
    end
    hold = 0; pend = '0;
    run(6);
    // Timeout, then the next requester is served
    set_req(3, 32'h30, 8'h00, 1'b0);
    slv_w = 100;
    g0 = gq_idx.size(); r0 = rq_idx.size();
    run(2);
    set_req(0, 32'h40, 8'h00, 1'b0);
    slv_w = 0; slv_data = 8'h5A;
    run(TIMEOUT + 10);
    expect_xfer("to", g0, r0, 3, TIMEOUT + 1, 8'h00, 1'b1);
    expect_xfer("to_next", g0 + 1, r0 + 1, 0, 4, 8'h5A, 1'b0);
    if (gq_idx.size() > g0 + 1 && rq_idx.size() > r0)
      chk("to_regrant_gap", gq_cyc[g0 + 1] - rq_cyc[r0], 1);
    // pready arriving during RESP after a timeout
    set_req(1, 32'h50, 8'h00, 1'b0);
    slv_w = TIMEOUT - 2; slv_data = 8'hEE;
    g0 = gq_idx.size(); r0 = rq_idx.size(); s0 = setup_cnt; l0 = late_seen;
    run(TIMEOUT + 8);
    expect_xfer("late", g0, r0, 1, TIMEOUT + 1, 8'h00, 1'b1);
    chk("late_rsp_count", rq_idx.size() - r0, 1);
    chk("late_setups", setup_cnt - s0, 1);
    chk("late_pready_in_resp", late_seen - l0, 1);
    // Reset during the enable phase
    set_req(2, 32'h60, 8'h99, 1'b1);
    slv_w = 100;
    r0 = rq_idx.size();
    run(3);
    preset = 1'b1;
    run(2);
    chk("mid_no_rsp", rq_idx.size() - r0, 0);
    preset = 1'b0;
    set_req(0, 32'h70, 8'h01, 1'b0);
    set_req(2, 32'h60, 8'h99, 1'b1);
    set_req(3, 32'h80, 8'h03, 1'b1);
    slv_w = 0; slv_data = 8'h42;
    g0 = gq_idx.size(); r0 = rq_idx.size();
    run(1);
    chk("mid_first_have", gq_idx.size() > g0, 1);
    if (gq_idx.size() > g0) chk("mid_first_gnt", gq_idx[g0], 0);
    run(14);
    chk("mid_rsp_count", rq_idx.size() - r0, 3);
    // Randomised traffic against the reference model
    rmode = 1;
    run(3000);
    rmode = 0; pend = '0;
    run(60);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Round-robin arbiter that shares one `apb_master` command port among NREQ requesters. It owns the master's `addrin/datain/wr/newd` inputs and observes `penable/pready/dataout`. It sequences exactly one APB transfer at a time and returns read data or a timeout error to the winning requester. It sits between the requester clients and the APB master instance in the subsystem.

## Interface
- NREQ, 4: number of requesters; legal range 2..16.
- AW, 32: address width; matches `apb_master` addrin.
- DW, 8: data width; matches `apb_master` datain/prdata.
- TIMEOUT, 16: maximum cycles spent in ACCESS before abort; legal range ≥4.
- pclk  in  1  sole clock, rising edge.
- preset  in  1  reset, asynchronous, active-high.
- req_valid  in  NREQ  per-requester transfer request, held until accepted.
- req_wr  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*AW  packed; requester i at [i*AW +: AW].
- req_wdata  in  NREQ*DW  packed; requester i at [i*DW +: DW].
- req_ready  out  NREQ  one-hot, one-cycle accept pulse.
- rsp_valid  out  NREQ  one-hot, one-cycle completion pulse.
- rsp_rdata  out  DW  read data, valid with rsp_valid; 0 for writes and errors.
- rsp_err  out  1  timeout flag, valid with rsp_valid.
- m_addr  out  AW  to master addrin.
- m_wdata  out  DW  to master datain.
- m_wr  out  1  to master wr.
- m_newd  out  1  to master newd.
- m_penable  in  1  from master penable.
- m_pready  in  1  APB pready, as seen by the master.
- m_dataout  in  DW  from master dataout.

## Operation
- FSM states and transitions:
  - IDLE → ACCESS when any req_valid is high.
  - ACCESS → RESP on completion or timeout.
  - RESP → IDLE unconditionally.
- IDLE arbitration:
  - Round-robin search starts at index last_gnt+1 mod NREQ; the first requester with req_valid high wins.
  - In the same cycle: pulse req_ready[win], and register win into gnt and the winner's addr/wdata/wr into m_addr/m_wdata/m_wr.
  - The requester's handshake completes at that edge.
- ACCESS:
  - m_addr/m_wdata/m_wr hold stable throughout.
  - m_newd = (state==ACCESS) && !(m_penable && m_pready), combinational. Newd therefore drops in the completion cycle, so the master returns to idle and never starts a back-to-back transfer.
  - Completion = m_penable && m_pready. On completion, capture rdata = m_wr ? 0 : m_dataout and set err=0.
  - A cycle counter clears on ACCESS entry and increments each ACCESS cycle. If count == TIMEOUT-1 and there is no completion in that cycle, set err=1 and rdata=0.
- RESP:
  - Pulse rsp_valid[gnt], driving rsp_rdata and rsp_err.
  - Set last_gnt = gnt.
  - m_newd = 0.
- A pready arriving while the arbiter is already in RESP after a timeout is ignored. The master sees newd=0 and idles.
- Reset values:
  - state = IDLE, last_gnt = NREQ-1 (requester 0 has first priority), counter 0.
  - All outputs 0: req_ready, rsp_valid, rsp_rdata, rsp_err, m_addr, m_wdata, m_wr, m_newd.
- Reset mid-transfer: abort immediately with no rsp_valid. The requester must re-issue.
- Simultaneous requests: exactly one winner per arbitration. The losers keep req_valid high and compete again after RESP.
- A requester that drops req_valid before it is accepted is simply skipped. This is not an error.

## Timing
- Cycle 0 (IDLE): req_ready pulse.
- Cycle 1: ACCESS begins, m_newd=1.
- Cycle 2: master is in setup.
- Cycle 3: master is in enable. With zero wait states, pready=1 here, so this is the completion cycle and m_newd=0.
- Cycle 4: RESP, rsp_valid.
- Cycle 5: IDLE, next arbitration.
- Minimum latency is 4 cycles from req_ready to rsp_valid. Each pready wait state adds 1 cycle.
- Sustained throughput with zero wait states is 1 transfer per 5 cycles.
- Timeout: ACCESS lasts at most TIMEOUT cycles, so rsp_valid with err arrives at cycle TIMEOUT+1 after req_ready.
- rsp_rdata and rsp_err are registered and stable for the single RESP cycle. Both are 0 outside RESP.

## Test plan
- Single read:
  - Stimulus: req_valid[2]=1, addr=0x0000_0010, wr=0; slave returns prdata=0xA5 with pready=1 on the first enable cycle.
  - Response: req_ready[2] at T, m_newd high for T+1..T+2, rsp_valid[2] at T+4 with rdata=0xA5 and err=0.
- Single write:
  - Stimulus: req 1, addr=0x20, wdata=0x3C, slave inserts 2 wait states.
  - Response: m_addr/m_wdata stable through ACCESS; rsp_valid[1] at T+6 with rdata=0x00 and err=0; exactly one APB transfer (one setup phase) observed.
- Round-robin fairness:
  - Stimulus: all 4 req_valid held high from reset.
  - Response: grant order 0,1,2,3,0,1; each req_ready pulse spaced 5 cycles apart with zero wait states.
- Timeout:
  - Stimulus: TIMEOUT=16, slave never asserts pready.
  - Response: rsp_valid with err=1 and rdata=0 at T+17; master returns to idle; next requester is granted afterwards.
- Reset mid-transfer:
  - Stimulus: assert preset during the master's enable phase.
  - Response: all outputs go to 0 asynchronously with no rsp_valid; after release, requester 0 wins first.
- Late pready:
  - Stimulus: pready arrives in the RESP cycle after a timeout.
  - Response: ignored; no second rsp_valid and no new setup phase.
